// File: rtl/clock_set_ctrl_pkg.sv
// Shared mode encodings and counter sizing for the clock set controller.
package clock_ctrl_pkg;

   localparam int MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_RUN   = 2'd0;
   localparam logic [MODE_W-1:0] MODE_SET_H = 2'd1;
   localparam logic [MODE_W-1:0] MODE_SET_M = 2'd2;

   typedef enum logic [MODE_W-1:0] {
      ST_RUN   = MODE_RUN,
      ST_SET_H = MODE_SET_H,
      ST_SET_M = MODE_SET_M
   } state_e;

   // Bits needed to hold 0..max_val inclusive.
   function automatic int ctr_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button/tick inputs and command outputs between the debouncers, this controller and the time counters.
interface clock_set_ctrl_if;
   import clock_ctrl_pkg::*;

   logic              tick_i;
   logic              btn_mode_i;
   logic              btn_inc_i;
   logic              run_en_o;
   logic              inc_h_o;
   logic              inc_m_o;
   logic              clr_s_o;
   logic [MODE_W-1:0] mode_o;
   logic              blink_o;

   modport master (
      output tick_i, btn_mode_i, btn_inc_i,
      input  run_en_o, inc_h_o, inc_m_o, clr_s_o, mode_o, blink_o
   );

   modport slave (
      input  tick_i, btn_mode_i, btn_inc_i,
      output run_en_o, inc_h_o, inc_m_o, clr_s_o, mode_o, blink_o
   );

endinterface

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Rising-edge detector with hold-to-repeat: one pulse on the press, then after
// REPEAT_DELAY cycles held, one every REPEAT_RATE cycles. Pulse is combinational.
module btn_repeat #(
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  logic clk_main,
   input  logic rst_i,
   input  logic level,
   input  logic enable,
   input  logic flush,
   output logic pulse
);
   import clock_ctrl_pkg::*;

   localparam int CW = ctr_w((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
   localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

   logic          prev_q, armed_q, rate_q;
   logic [CW-1:0] cnt_q;
   logic          rise, live, hit;

   assign rise  = level & ~prev_q;
   assign live  = enable & ~flush & level;
   assign hit   = armed_q & (cnt_q == (rate_q ? RATE_LAST : DLY_LAST));
   assign pulse = live & (rise | hit);

   // Only a rise seen while live arms the repeater, so a press carried across a
   // flush or a disabled period never repeats until it is pressed again.
   always_ff @(posedge clk_main or posedge rst_i) begin
      if (rst_i) begin
         prev_q  <= 1'b1;
         armed_q <= 1'b0;
         rate_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         prev_q <= level;
         if (!live) begin
            armed_q <= 1'b0;
            rate_q  <= 1'b0;
            cnt_q   <= '0;
         end else if (rise) begin
            armed_q <= 1'b1;
            rate_q  <= 1'b0;
            cnt_q   <= '0;
         end else if (hit) begin
            rate_q <= 1'b1;
            cnt_q  <= '0;
         end else if (armed_q) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// RUN / SET_H / SET_M controller driving the time counters and display blink.
// Define SET_TIMEOUT_EN to return to RUN after TIMEOUT_S idle ticks in a set mode.
module clock_set_ctrl #(
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100,
   parameter int BLINK_HALF   = 250,
   parameter int TIMEOUT_S    = 10
) (
   input  logic              clk_main,
   input  logic              rst_i,
   clock_set_ctrl_if.slave   bus
);
   import clock_ctrl_pkg::*;

   localparam int BW = ctr_w(BLINK_HALF);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   state_e        state_q, state_d;
   logic          mode_prev, mode_rise, set_mode, inc_pulse, timeout;
   logic          run_en_q, inc_h_q, inc_m_q, clr_s_q, blink_q;
   logic          inc_h_d, inc_m_d, clr_s_d, blink_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;

   assign mode_rise = bus.btn_mode_i & ~mode_prev;
   assign set_mode  = (state_q == ST_SET_H) || (state_q == ST_SET_M);

   // A MODE press in the same cycle flushes INC so the mode change always wins.
   btn_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_inc_rpt (
      .clk_main (clk_main),
      .rst_i    (rst_i),
      .level    (bus.btn_inc_i),
      .enable   (set_mode),
      .flush    (mode_rise),
      .pulse    (inc_pulse)
   );

`ifdef SET_TIMEOUT_EN
   localparam int IW = ctr_w(TIMEOUT_S);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);
   logic [IW-1:0] idle_q;

   assign timeout = set_mode & ~mode_rise & ~inc_pulse & bus.tick_i & (idle_q == IDLE_LAST);

   always_ff @(posedge clk_main or posedge rst_i) begin
      if (rst_i)                                             idle_q <= '0;
      else if (!set_mode || mode_rise || inc_pulse || timeout) idle_q <= '0;
      else if (bus.tick_i)                                   idle_q <= idle_q + 1'b1;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{bus.tick_i, 32'(TIMEOUT_S)};
   assign timeout    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      clr_s_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mode_rise) begin
               state_d = ST_SET_H;
               clr_s_d = 1'b1;
            end
         end
         ST_SET_H: begin
            if (mode_rise)    state_d = ST_SET_M;
            else if (timeout) state_d = ST_RUN;
         end
         ST_SET_M: begin
            if (mode_rise || timeout) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      inc_h_d = inc_pulse & (state_q == ST_SET_H);
      inc_m_d = inc_pulse & (state_q == ST_SET_M);

      // Entering a set mode or bumping a digit shows the field solid before blinking.
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (state_d == ST_RUN || state_d != state_q || inc_pulse) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_d     = ~blink_q;
         blink_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_main or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         mode_prev   <= 1'b1;
         run_en_q    <= 1'b1;
         inc_h_q     <= 1'b0;
         inc_m_q     <= 1'b0;
         clr_s_q     <= 1'b0;
         blink_q     <= 1'b1;
         blink_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_prev   <= bus.btn_mode_i;
         run_en_q    <= (state_d == ST_RUN);
         inc_h_q     <= inc_h_d;
         inc_m_q     <= inc_m_d;
         clr_s_q     <= clr_s_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign bus.mode_o   = state_q;
   assign bus.run_en_o = run_en_q;
   assign bus.inc_h_o  = inc_h_q;
   assign bus.inc_m_o  = inc_m_q;
   assign bus.clr_s_o  = clr_s_q;
   assign bus.blink_o  = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed plus random stimulus for clock_set_ctrl against a behavioural model
// built from press ages, hold ages and blink ages.
module tb_clock_set_ctrl;

   localparam int D  = 8;
   localparam int R  = 4;
   localparam int BH = 3;
   localparam int TO = 5;

   logic clk_main = 1'b0;
   logic rst_i;

   clock_set_ctrl_if bus();

   clock_set_ctrl #(
      .REPEAT_DELAY (D),
      .REPEAT_RATE  (R),
      .BLINK_HALF   (BH),
      .TIMEOUT_S    (TO)
   ) dut (
      .clk_main (clk_main),
      .rst_i    (rst_i),
      .bus      (bus)
   );

   always #5 clk_main = ~clk_main;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int m_mode, m_age, m_bage, m_idle;
   bit m_pm, m_pi, m_armed, m_inc_h, m_inc_m, m_clr;

   task automatic model_reset();
      m_mode = 0; m_age = 0; m_bage = 0; m_idle = 0;
      m_pm = 1'b1; m_pi = 1'b1; m_armed = 1'b0;
      m_inc_h = 1'b0; m_inc_m = 1'b0; m_clr = 1'b0;
   endtask

   task automatic model_step(input bit m, input bit i, input bit t);
      bit mr, ir, set, pulse;
      int nm;
      mr = m && !m_pm;
      ir = i && !m_pi;
      m_pm = m;
      m_pi = i;
      set = (m_mode == 1) || (m_mode == 2);
      pulse = 1'b0;
      if (!set || mr || !i) m_armed = 1'b0;
      else if (ir) begin
         m_armed = 1'b1; m_age = 0; pulse = 1'b1;
      end else if (m_armed) begin
         m_age++;
         if (m_age >= D && (m_age - D) % R == 0) pulse = 1'b1;
      end
      nm = m_mode;
      m_clr = 1'b0;
      if (mr) begin
         nm = (m_mode + 1) % 3;
         m_clr = (m_mode == 0);
      end
      if (!set || mr || pulse) m_idle = 0;
      else if (t) m_idle++;
`ifdef SET_TIMEOUT_EN
      if (m_idle == TO) begin
         nm = 0; m_idle = 0;
      end
`endif
      m_inc_h = pulse && (m_mode == 1);
      m_inc_m = pulse && (m_mode == 2);
      if (nm == 0 || nm != m_mode || pulse) m_bage = 0;
      else m_bage++;
      m_mode = nm;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic exp_blink;
      exp_blink = (m_mode == 0) ? 1'b1 : ((m_bage / BH) % 2 == 0);
      chk({tag, ".mode"},   8'(bus.mode_o),   8'(m_mode));
      chk({tag, ".run_en"}, 8'(bus.run_en_o), 8'(m_mode == 0));
      chk({tag, ".inc_h"},  8'(bus.inc_h_o),  8'(m_inc_h));
      chk({tag, ".inc_m"},  8'(bus.inc_m_o),  8'(m_inc_m));
      chk({tag, ".clr_s"},  8'(bus.clr_s_o),  8'(m_clr));
      chk({tag, ".blink"},  8'(bus.blink_o),  8'(exp_blink));
   endtask

   task automatic step(input bit m, input bit i, input bit t, input string tag);
      bus.btn_mode_i = m;
      bus.btn_inc_i  = i;
      bus.tick_i     = t;
      @(posedge clk_main);
      model_step(m, i, t);
      #1 check_all(tag);
   endtask

   initial begin
      int hold_q[$];
      int exp_k[4] = '{1, 9, 13, 17};
      int exp_seq[3] = '{1, 2, 0};
      bit rm, ri;

      // Reset with MODE already held
      rst_i = 1'b1;
      bus.btn_mode_i = 1'b1;
      bus.btn_inc_i  = 1'b0;
      bus.tick_i     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_main);
      #1 check_all("reset");
      rst_i = 1'b0;
      repeat (3) step(1, 0, 0, "held_mode");
      step(0, 0, 0, "idle");

      // Three MODE presses cycle the modes
      for (int p = 0; p < 3; p++) begin
         step(1, 0, 0, "press");
         chk("press.seq", 8'(bus.mode_o), 8'(exp_seq[p]));
         repeat (4) step(0, 0, 0, "between");
      end

      // Hold INC in SET_H
      step(1, 0, 0, "to_set_h");
      step(0, 0, 0, "idle");
      for (int k = 1; k <= 26; k++) begin
         step(0, (k <= 20), 0, "hold");
         if (bus.inc_h_o === 1'b1) hold_q.push_back(k);
      end
      chk("hold.count", 8'(hold_q.size()), 8'd4);
      for (int n = 0; n < 4; n++)
         chk("hold.when", 8'((hold_q.size() > n) ? hold_q[n] : 255), 8'(exp_k[n]));

      // SET_M blink, INC bump, then MODE+INC together
      step(1, 0, 0, "to_set_m");
      repeat (10) step(0, 0, 0, "blink");
      step(0, 1, 0, "bump");
      chk("bump.blink", 8'(bus.blink_o), 8'd1);
      step(0, 0, 0, "idle");
      step(1, 1, 0, "mode_inc");
      chk("mode_inc.mode", 8'(bus.mode_o), 8'd0);
      chk("mode_inc.inc_m", 8'(bus.inc_m_o), 8'd0);
      step(0, 1, 0, "held");
      step(0, 0, 0, "idle");

      // INC in RUN is ignored
      step(0, 1, 0, "run_inc");
      step(0, 0, 0, "idle");

      // Reset mid-hold; INC still held afterwards must not act
      step(1, 0, 0, "to_set_h");
      repeat (10) step(0, 1, 0, "hold2");
      #2 rst_i = 1'b1;
      model_reset();
      #1 check_all("midrst");
      @(posedge clk_main);
      #1 rst_i = 1'b0;
      step(0, 1, 0, "post_rst");
      step(1, 1, 0, "to_set_h");
      repeat (12) step(0, 1, 0, "stale_hold");
      step(0, 0, 0, "idle");
      chk("pre_tick.mode", 8'(bus.mode_o), 8'd1);

      // Idle ticks in SET_H, INC on the 4th restarts the count
      for (int n = 1; n <= 3; n++) begin
         step(0, 0, 1, "tick");
         step(0, 0, 0, "idle");
      end
      step(0, 1, 1, "tick_inc");
      step(0, 0, 0, "idle");
      for (int n = 1; n <= 5; n++) begin
         step(0, 0, 1, "tick");
         step(0, 0, 0, "idle");
      end
`ifdef SET_TIMEOUT_EN
      chk("timeout.mode", 8'(bus.mode_o), 8'd0);
`else
      chk("timeout.mode", 8'(bus.mode_o), 8'd1);
`endif
      step(0, 0, 1, "tick10");
`ifdef SET_TIMEOUT_EN
      chk("tick10.mode", 8'(bus.mode_o), 8'd0);
`else
      chk("tick10.mode", 8'(bus.mode_o), 8'd1);
`endif

      // Random levels and ticks
      rm = 1'b0;
      ri = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(5, 0) == 0) rm = ~rm;
         if ($urandom_range(6, 0) == 0) ri = ~ri;
         step(rm, ri, ($urandom_range(4, 0) == 0), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode and time-setting controller for the HH:MM:SS timekeeping datapath. It takes debounced MODE and INC button levels and runs a RUN / SET_H / SET_M state machine. It drives single-cycle increment/clear commands and a run enable into the time counters, plus a blink flag for the display. It sits between the button debouncers and the time counter block, all on clk_main.

Parameters:
REPEAT_DELAY, 500, clk_main cycles INC must be held after its rising edge before auto-repeat starts (≥1)
REPEAT_RATE, 100, clk_main cycles between auto-repeat pulses (≥1)
BLINK_HALF, 250, clk_main cycles per blink half-period in set modes (≥1)
TIMEOUT_S, 10, tick_i pulses of inactivity before returning to RUN (SET_TIMEOUT_EN only)

Ports:
clk_main  in  1  main clock
rst_i  in  1  reset, asynchronous, active-high
tick_i  in  1  1 Hz enable, one clk_main cycle wide
btn_mode_i  in  1  debounced MODE level
btn_inc_i  in  1  debounced INC level
run_en_o  out  1  seconds counter enable (1 only in RUN)
inc_h_o  out  1  one-cycle hour increment command
inc_m_o  out  1  one-cycle minute increment command
clr_s_o  out  1  one-cycle seconds clear command
mode_o  out  2  current state encoding
blink_o  out  1  display blink gate for the field being set

Behaviour:
- Reset is asynchronous on rst_i and clocked by clk_main: state=RUN, mode_o=0, run_en_o=1, inc_h_o/inc_m_o/clr_s_o=0, blink_o=1, all counters 0.
- Reset sets the button-history registers to 1, so a button already held at reset release produces no edge.
- Edge detection: rise = level & ~prev, evaluated each clk_main edge. All outputs are registered, so a level rising before edge n gives the pulse/state change visible after edge n (1-cycle latency).
- State encoding: RUN=0, SET_H=1, SET_M=2. Value 3 is illegal and recovers to RUN on the next edge.
- MODE rise transitions:
  - RUN->SET_H, with clr_s_o pulsed for 1 cycle in the same cycle.
  - SET_H->SET_M.
  - SET_M->RUN.
- run_en_o = (state==RUN), registered together with the state.
- INC rise:
  - In SET_H: inc_h_o pulses 1 cycle.
  - In SET_M: inc_m_o pulses 1 cycle.
  - In RUN: ignored, no pulse.
- Auto-repeat while INC is held in a set state:
  - Repeat counter loads 0 on the INC rise.
  - Once it reaches REPEAT_DELAY, a further pulse is issued, then one every REPEAT_RATE cycles.
  - INC release clears the counter; no pulse is issued on release.
  - Counter width is $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1); it must never wrap.
- Simultaneous MODE rise and INC rise/repeat in the same cycle: MODE wins, no increment pulse, repeat counter cleared. A still-held INC does not repeat in the new state until a new rise.
- inc_h_o and inc_m_o are never asserted together. Neither is asserted in the same cycle as clr_s_o.
- Blink:
  - In RUN, blink_o=1 constant and the blink counter is held at 0.
  - In set states, blink_o toggles every BLINK_HALF cycles, starting at 1 on entry.
  - Any increment pulse forces blink_o=1 and restarts the blink counter, so the changed digit is visible.
- tick_i is ignored except by the optional timeout. Wrap-around of hours/minutes belongs to the counter block, not this block.
- rst_i asserted mid-hold or mid-repeat: immediate return to reset values. After release, a held INC needs a fresh rise.

Optional Feature:
SET_TIMEOUT_EN:
- Defined:
  - In SET_H/SET_M, an idle counter counts tick_i pulses.
  - It clears on any MODE/INC rise or repeat pulse.
  - When it reaches TIMEOUT_S, state returns to RUN on that edge (run_en_o=1, no clr_s_o).
  - A tick coinciding with a button rise: the clear wins.
- Undefined: no idle counter; set states persist indefinitely. TIMEOUT_S is unused.

Decomposition:
- Package clock_ctrl_pkg:
  - mode localparams MODE_RUN=2'd0, MODE_SET_H=2'd1, MODE_SET_M=2'd2;
  - MODE_W=2;
  - a width helper for counter sizing.
- Sub-module btn_repeat:
  - edge detect plus delay/rate auto-repeat generator, params REPEAT_DELAY/REPEAT_RATE;
  - inputs clk_main, rst_i, level, enable, flush;
  - output pulse.
  - Instantiated once for INC. MODE uses an inline edge detector.

Test Plan:
(Bench params REPEAT_DELAY=8, REPEAT_RATE=4, BLINK_HALF=3, TIMEOUT_S=5.)
- Reset with btn_mode_i held at 1, then release rst_i -> mode_o stays 0, run_en_o=1, no clr_s_o.
- Three MODE presses, each 1 cycle high, 5 apart -> mode_o 1,2,0. clr_s_o pulses only on the first press. run_en_o is 0 between the first and third press.
- In SET_H, hold INC for 20 cycles -> inc_h_o at rise+1, then at cycles +9, +13, +17 after the rise; nothing after release.
- In RUN, pulse INC -> no inc_h_o/inc_m_o. In SET_M, MODE and INC rise in the same cycle -> mode_o=0, no inc_m_o.
- In SET_M with no button activity -> blink_o toggles every 3 cycles. An INC pulse forces blink_o=1 on the pulse cycle.
- With SET_TIMEOUT_EN: SET_H, then 5 tick_i pulses with no buttons -> mode_o=0 after the 5th tick. An INC at tick 4 restarts the count. Without the macro -> still SET_H after 10 ticks.
